fbin_fbcd_seq: RTL and testbench
================================

# fbin_fbcd_seq

Sequential, parametrised converter from an unsigned binary fraction (0.b₋₁b₋₂…) to a packed BCD decimal fraction in the calculator datapath. It generalises the fixed 4-bit combinational fraction-to-BCD decoder to any fraction width and digit count. It produces one decimal digit per clock by repeated multiply-by-10, under a start/done handshake. It sits between the binary arithmetic core and the display formatter.

## Interface
- `FRAC_W`, 8, input fraction width; bit `FRAC_W-1` has weight 2⁻¹. Legal range is ≥1.
- `DIGITS`, 4, number of decimal fraction digits output. Legal range is ≥1.

- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request conversion; sampled only while `ready`=1.
- `frac_in`  in  FRAC_W  binary fraction; captured on the accepting edge only.
- `ready`  out  1  idle and able to accept `start`.
- `done`  out  1  one-cycle pulse: `bcd_out`/`exact`/`carry_out` are valid.
- `bcd_out`  out  4*DIGITS  packed BCD. Top nibble is the 10⁻¹ digit; bottom nibble is the 10⁻ᴰᴵᴳᴵᵀˢ digit.
- `exact`  out  1  the fraction is exactly represented in DIGITS digits (remainder zero).
- `carry_out`  out  1  rounding carried past 10⁻¹; the value is 1.000…. Always 0 without ROUND_EN.

## Operation
- States:
  - IDLE: `ready`=1.
  - CONV: one digit per cycle.
  - GUARD: ROUND_EN only; computes the guard digit.
  - ROUND: ROUND_EN only; applies the decimal increment.
- Accumulator `acc` is FRAC_W bits wide. Each step:
  - `p = (acc<<3)+(acc<<1)`, computed FRAC_W+4 bits wide.
  - The digit is `p[FRAC_W+3:FRAC_W]`, always 0–9.
  - `acc ← p[FRAC_W-1:0]`.
  - The digit shifts into `bcd_out` from the low end, most significant digit first.
- IDLE + `start`: load `acc ← frac_in`, clear the digit counter, go to CONV.
- CONV: after DIGITS digits, latch `exact = (acc==0)` on the remainder after the last digit. Then:
  - without ROUND_EN, go to IDLE;
  - with ROUND_EN, go to GUARD.
- GUARD: compute the next digit as guard digit `g`; do not shift it into `bcd_out`. Go to ROUND.
- ROUND: if `g`≥5, add 1 to the BCD value with decimal carry across all digits. A carry out of the top digit wraps the digits to 0 and sets `carry_out`=1. Go to IDLE.
- `bcd_out`, `exact` and `carry_out` hold their values until the next accepted `start`. They are cleared on that accepting edge.
- `start` while `ready`=0 is ignored. It is not queued.
- `frac_in` changes after the accepting edge have no effect.

## Timing
- Reset values, applied immediately and asynchronously:
  - state IDLE, `ready`=1, `done`=0;
  - `bcd_out`=0, `exact`=0, `carry_out`=0.
- `start` accepted at edge E0. `ready` is 0 from E0 until the transition back to IDLE.
- Without ROUND_EN:
  - digits are produced at edges E1…E_DIGITS;
  - `done`=1 and `ready`=1 in the cycle after E_DIGITS;
  - latency is DIGITS+1 edges from the accepting edge to the end of the `done` cycle.
- With ROUND_EN: guard digit at E_DIGITS+1, rounding at E_DIGITS+2, then `done` and `ready` in the following cycle.
- `done` is registered and lasts exactly one cycle.
- `start` in the `done` cycle is accepted (`ready`=1); `done` still drops next cycle.
- Back-to-back conversions are possible at one per DIGITS+1 cycles, or DIGITS+3 cycles with ROUND_EN.
- `rst` mid-conversion aborts immediately to the reset values. No `done` is produced.

## Configuration
- Macro: `FBIN_FBCD_ROUND_EN`.
- Defined: round half-up using the GUARD and ROUND states; `carry_out` is live.
- Undefined: truncation; GUARD and ROUND are absent; `carry_out` is tied to 0. `exact` has the same meaning in both builds.

## Test plan
- FRAC_W=4, DIGITS=4: sweep all 16 values of `frac_in`. Examples:
  - `0001` → `bcd_out`=0x0625, `exact`=1;
  - `1111` → 0x9375, `exact`=1.
  - `done` falls exactly 5 edges after `start`.
- FRAC_W=8, DIGITS=4:
  - 0x55 → 0x3320, `exact`=0 (both builds);
  - 0xFF → 0x9960 truncated, 0x9961 with ROUND_EN.
- FRAC_W=16, DIGITS=4, ROUND_EN, 0xFFFF → `bcd_out`=0x0000, `carry_out`=1, `exact`=0.
- `start` pulsed while busy → ignored. `start` held through the `done` cycle → second conversion accepted with no idle gap, and the result is correct.
- `rst` asserted at E2 of a conversion → all outputs go to their reset values within the same cycle. No `done`; the next conversion completes correctly.
- FRAC_W=1, DIGITS=1, `frac_in`=1 → 0x5, `exact`=1. `frac_in`=0 → 0x0, `exact`=1.

Source files
------------

// File: rtl/fbin_fbcd_seq.sv
// Sequential binary-fraction to packed-BCD converter, one decimal digit per clock (x10 per step).
// Optional round half-up via guard digit when FBIN_FBCD_ROUND_EN is defined.
module fbin_fbcd_seq #(
  parameter int unsigned FRAC_W = 8,
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [FRAC_W-1:0]     frac_in,
  output logic                  ready,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  exact,
  output logic                  carry_out
);

  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LastCnt = CW'(DIGITS - 1);

`ifdef FBIN_FBCD_ROUND_EN
  typedef enum logic [1:0] {StIdle, StConv, StGuard, StRound} state_e;
`else
  typedef enum logic [0:0] {StIdle, StConv} state_e;
`endif

  state_e              state_q, state_d;
  logic [FRAC_W-1:0]   acc_q, acc_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [BW-1:0]       bcd_q, bcd_d;
  logic                exact_q, exact_d;
  logic                done_q, done_d;
  logic [FRAC_W+3:0]   p;
  logic [3:0]          digit;
  logic [BW-1:0]       shifted;

`ifdef FBIN_FBCD_ROUND_EN
  logic                round_q, round_d;
  logic                carry_q, carry_d;

  // Decimal +1 across all digits; MSB of the result is the carry out of the top digit.
  function automatic logic [BW:0] bcd_inc(input logic [BW-1:0] v);
    logic [BW-1:0] r;
    logic          c;
    c = 1'b1;
    r = v;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return {c, r};
  endfunction
`endif

  always_comb begin
    p       = ({4'b0000, acc_q} << 3) + ({4'b0000, acc_q} << 1);
    digit   = p[FRAC_W+3:FRAC_W];
    shifted = bcd_q << 4;
    shifted[3:0] = digit;

    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    exact_d = exact_q;
    done_d  = 1'b0;
`ifdef FBIN_FBCD_ROUND_EN
    round_d = round_q;
    carry_d = carry_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (start) begin
          acc_d   = frac_in;
          cnt_d   = '0;
          bcd_d   = '0;
          exact_d = 1'b0;
`ifdef FBIN_FBCD_ROUND_EN
          carry_d = 1'b0;
`endif
          state_d = StConv;
        end
      end
      StConv: begin
        acc_d = p[FRAC_W-1:0];
        bcd_d = shifted;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          exact_d = (p[FRAC_W-1:0] == '0);
`ifdef FBIN_FBCD_ROUND_EN
          state_d = StGuard;
`else
          state_d = StIdle;
          done_d  = 1'b1;
`endif
        end
      end
`ifdef FBIN_FBCD_ROUND_EN
      StGuard: begin
        round_d = (digit >= 4'd5);
        state_d = StRound;
      end
      StRound: begin
        if (round_q) begin
          {carry_d, bcd_d} = bcd_inc(bcd_q);
        end
        state_d = StIdle;
        done_d  = 1'b1;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      exact_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef FBIN_FBCD_ROUND_EN
      round_q <= 1'b0;
      carry_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      exact_q <= exact_d;
      done_q  <= done_d;
`ifdef FBIN_FBCD_ROUND_EN
      round_q <= round_d;
      carry_q <= carry_d;
`endif
    end
  end

  assign ready   = (state_q == StIdle);
  assign done    = done_q;
  assign bcd_out = bcd_q;
  assign exact   = exact_q;
`ifdef FBIN_FBCD_ROUND_EN
  assign carry_out = carry_q;
`else
  assign carry_out = 1'b0;
`endif

endmodule

// File: tb/tb_fbin_fbcd_seq.sv
// Scoreboard bench for fbin_fbcd_seq: arithmetic reference model, directed known answers,
// busy/back-to-back/reset-abort scenarios and randomized traffic.
module tb_fbin_fbcd_seq;

  localparam int unsigned W  = 8;
  localparam int unsigned D  = 4;
  localparam int unsigned BW = 4 * D;
`ifdef FBIN_FBCD_ROUND_EN
  localparam int unsigned LAT = D + 2;
`else
  localparam int unsigned LAT = D;
`endif

  logic          clk, rst, start, ready, done, exact, carry_out;
  logic [W-1:0]  frac_in;
  logic [BW-1:0] bcd_out;

  fbin_fbcd_seq #(.FRAC_W(W), .DIGITS(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .frac_in   (frac_in),
    .ready     (ready),
    .done      (done),
    .bcd_out   (bcd_out),
    .exact     (exact),
    .carry_out (carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [BW-1:0] bcd;
    logic          exact;
    logic          carry;
    int unsigned   done_at;
  } exp_t;

  exp_t          sbq[$];
  int            tests = 0;
  int            fails = 0;
  int unsigned   n_done = 0;
  int unsigned   n_push = 0;
  logic [BW-1:0] last_bcd;
  logic          last_exact;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Value = f * 10^D / 2^W; digits are the integer part, exactness is a zero remainder.
  function automatic exp_t model(input logic [W-1:0] f, input int unsigned at);
    exp_t e;
    longint unsigned scale, num, den, q, r;
    scale = 1;
    for (int i = 0; i < int'(D); i++) scale = scale * 10;
    den = 64'd1 << W;
    num = longint'(f) * scale;
    q = num / den;
    r = num % den;
    e.exact = (r == 0);
    e.carry = 1'b0;
`ifdef FBIN_FBCD_ROUND_EN
    if (2 * r >= den) q = q + 1;
    if (q == scale) begin
      q = 0;
      e.carry = 1'b1;
    end
`endif
    e.bcd = '0;
    for (int i = 0; i < int'(D); i++) begin
      e.bcd[4*i +: 4] = 4'(q % 10);
      q = q / 10;
    end
    e.done_at = at + LAT;
    return e;
  endfunction

  task automatic reset_check(input string tag);
    chk({tag, "_ready"}, ready, 1);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_bcd"}, bcd_out, 0);
    chk({tag, "_exact"}, exact, 0);
    chk({tag, "_carry"}, carry_out, 0);
  endtask

  // Waits for ready, starts one conversion; returns at the negedge after the accepting edge.
  task automatic issue(input logic [W-1:0] f, input bit push, output int unsigned k);
    int t;
    t = 0;
    k = 0;
    @(negedge clk);
    while (!ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!ready) begin
      chk("ready_timeout", ready, 1);
    end else begin
      frac_in = f;
      start   = 1'b1;
      k       = cyc + 1;
      if (push) begin
        sbq.push_back(model(f, k));
        n_push++;
      end
      @(negedge clk);
      start   = 1'b0;
      frac_in = W'($urandom);
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((sbq.size() != 0 || !ready) && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) begin
      chk("idle_timeout_queue", sbq.size(), 0);
      chk("idle_timeout_ready", ready, 1);
    end
  endtask

  logic [W-1:0]  dfrac  [6] = '{8'h10, 8'hF0, 8'h55, 8'hFF, 8'h00, 8'h80};
`ifdef FBIN_FBCD_ROUND_EN
  logic [BW-1:0] dbcd   [6] = '{16'h0625, 16'h9375, 16'h3320, 16'h9961, 16'h0000, 16'h5000};
`else
  logic [BW-1:0] dbcd   [6] = '{16'h0625, 16'h9375, 16'h3320, 16'h9960, 16'h0000, 16'h5000};
`endif
  logic          dexact [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    int unsigned ka, kb, kc;
    exp_t e;
    rst = 1'b0;
    start = 1'b0;
    frac_in = '0;

    fork
      forever begin
        @(negedge clk);
        if (!rst && done) begin
          n_done++;
          last_bcd   = bcd_out;
          last_exact = exact;
          if (sbq.size() == 0) begin
            chk("done_without_start", done, 0);
          end else begin
            e = sbq.pop_front();
            chk("bcd", bcd_out, e.bcd);
            chk("exact", exact, e.exact);
            chk("carry", carry_out, e.carry);
            chk("latency", cyc, e.done_at);
          end
        end
      end
    join_none

    #2 rst = 1'b1;
    #2 reset_check("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Known answers
    for (int i = 0; i < 6; i++) begin
      issue(dfrac[i], 1'b1, ka);
      wait_idle();
      chk($sformatf("known_bcd_%0h", dfrac[i]), last_bcd, dbcd[i]);
      chk($sformatf("known_exact_%0h", dfrac[i]), last_exact, dexact[i]);
    end

    // start while busy is ignored, and back-to-back acceptance in the done cycle
    issue(8'h33, 1'b1, ka);
    start = 1'b1;
    chk("busy_ready", ready, 0);
    @(negedge clk);
    start = 1'b0;
    issue(8'hC7, 1'b1, kb);
    issue(8'h01, 1'b1, kc);
    chk("b2b_gap1", kb - ka, LAT + 1);
    chk("b2b_gap2", kc - kb, LAT + 1);
    wait_idle();

    // Reset at E2 of a conversion aborts with no done
    issue(8'hFF, 1'b0, ka);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 reset_check("abort");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (LAT + 3) @(negedge clk);
    issue(8'h55, 1'b1, ka);
    wait_idle();
    chk("after_abort_bcd", last_bcd, 16'h3320);

    // Randomized traffic with random gaps and stray start pulses
    repeat (40) begin
      issue(W'($urandom), 1'b1, ka);
      if ($urandom_range(0, 3) == 0 && !ready) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle();
    repeat (LAT + 3) @(negedge clk);
    chk("done_count", n_done, n_push);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
